// File: rtl/deser1to4_ce.sv
`default_nettype none
// ============================================================================
// Module   : deser1to4_ce
// Brief    : Registered 1-to-4 serial-to-parallel deserializer with clock
//            enable and SYNC-marked word alignment.
// Revision : 1.0 - initial release
// ============================================================================
module deser1to4_ce #(
  parameter logic [3:0] INIT      = 4'b0000,
  parameter int         MSB_FIRST = 0
) (
  input  logic C,
  input  logic CLR,
  input  logic CE,
  input  logic D,
  input  logic SYNC,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic VALID,
  output logic SYNC_ERR
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  shift_q, shift_d;
  logic [3:0]  q_q, q_d;
  logic        valid_q, valid_d;
  logic        sync_err_q, sync_err_d;

  logic [3:0]  w_word;
  logic [3:0]  w_mapped;

  // Complete word in arrival order: bit k sits at w_word[k], D is bit 3.
  assign w_word = {D, shift_q};

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      for (genvar k = 0; k < 4; k++) begin : g_rev
        assign w_mapped[3-k] = w_word[k];
      end
    end else begin : g_lsb_first
      assign w_mapped = w_word;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    q_d        = q_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    if (CE) begin
      case (state_q)
        HUNT: begin
          if (SYNC) begin
            shift_d[0] = D;
            cnt_d      = 2'd1;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (SYNC) begin
            // A non-zero count means a partial word is being abandoned.
            sync_err_d = (cnt_q != 2'd0);
            shift_d[0] = D;
            cnt_d      = 2'd1;
          end else begin
            case (cnt_q)
              2'd0: shift_d[0] = D;
              2'd1: shift_d[1] = D;
              2'd2: shift_d[2] = D;
              default: begin
                q_d     = w_mapped;
                valid_d = 1'b1;
              end
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q    <= HUNT;
      cnt_q      <= 2'd0;
      shift_q    <= 3'd0;
      q_q        <= INIT;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign Q0       = q_q[0];
  assign Q1       = q_q[1];
  assign Q2       = q_q[2];
  assign Q3       = q_q[3];
  assign VALID    = valid_q;
  assign SYNC_ERR = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_deser1to4_ce.sv
`default_nettype none
// ============================================================================
// Module   : tb_deser1to4_ce
// Brief    : Self-checking bench for deser1to4_ce; an LSB-first and an
//            MSB-first instance share one stimulus stream and one word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deser1to4_ce;

  localparam logic [3:0] C_INIT = 4'b1010;

  logic C, CLR, CE, D, SYNC;
  logic l_q0, l_q1, l_q2, l_q3, l_valid, l_err;
  logic m_q0, m_q1, m_q2, m_q3, m_valid, m_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a word in progress is a queue of received bits.
  logic       mdl_hunting;
  int         mdl_bits[$];
  logic [3:0] mdl_q_lsb, mdl_q_msb;
  logic       mdl_valid, mdl_err;

  deser1to4_ce #(.INIT(C_INIT), .MSB_FIRST(0)) u_lsb (
    .C(C), .CLR(CLR), .CE(CE), .D(D), .SYNC(SYNC),
    .Q0(l_q0), .Q1(l_q1), .Q2(l_q2), .Q3(l_q3),
    .VALID(l_valid), .SYNC_ERR(l_err)
  );

  deser1to4_ce #(.INIT(C_INIT), .MSB_FIRST(1)) u_msb (
    .C(C), .CLR(CLR), .CE(CE), .D(D), .SYNC(SYNC),
    .Q0(m_q0), .Q1(m_q1), .Q2(m_q2), .Q3(m_q3),
    .VALID(m_valid), .SYNC_ERR(m_err)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_hunting = 1'b1;
    mdl_bits.delete();
    mdl_q_lsb = C_INIT;
    mdl_q_msb = C_INIT;
    mdl_valid = 1'b0;
    mdl_err   = 1'b0;
  endtask

  task automatic model_edge(input logic ce, input logic sync, input logic d);
    int w_l, w_m;
    mdl_valid = 1'b0;
    mdl_err   = 1'b0;
    if (ce) begin
      if (sync) begin
        mdl_err     = !mdl_hunting && (mdl_bits.size() > 0);
        mdl_bits    = {int'(d)};
        mdl_hunting = 1'b0;
      end else if (!mdl_hunting) begin
        mdl_bits.push_back(int'(d));
        if (mdl_bits.size() == 4) begin
          w_l = 0;
          w_m = 0;
          for (int k = 0; k < 4; k++) begin
            w_l += mdl_bits[k] * (2 ** k);
            w_m += mdl_bits[k] * (2 ** (3 - k));
          end
          mdl_q_lsb = 4'(w_l);
          mdl_q_msb = 4'(w_m);
          mdl_valid = 1'b1;
          mdl_bits.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q_lsb"}, {l_q3, l_q2, l_q1, l_q0}, mdl_q_lsb);
    chk({tag, "_q_msb"}, {m_q3, m_q2, m_q1, m_q0}, mdl_q_msb);
    chk({tag, "_valid_lsb"}, {3'b0, l_valid}, {3'b0, mdl_valid});
    chk({tag, "_valid_msb"}, {3'b0, m_valid}, {3'b0, mdl_valid});
    chk({tag, "_err_lsb"}, {3'b0, l_err}, {3'b0, mdl_err});
    chk({tag, "_err_msb"}, {3'b0, m_err}, {3'b0, mdl_err});
  endtask

  task automatic step(input string tag, input logic ce, input logic sync, input logic d);
    @(negedge C);
    CE = ce; SYNC = sync; D = d;
    @(posedge C);
    model_edge(ce, sync, d);
    #1;
    check_all(tag);
  endtask

  // Asserts CLR between clock edges and checks the outputs before any edge.
  task automatic async_clear(input string tag);
    @(negedge C);
    #1 CLR = 1'b1;
    #1;
    model_reset();
    chk({tag, "_q_lsb_async"}, {l_q3, l_q2, l_q1, l_q0}, C_INIT);
    chk({tag, "_q_msb_async"}, {m_q3, m_q2, m_q1, m_q0}, C_INIT);
    chk({tag, "_valid_async"}, {2'b0, l_valid, m_valid}, 4'b0);
    chk({tag, "_err_async"},   {2'b0, l_err, m_err}, 4'b0);
    #1 CLR = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [3:0] bits, input logic first_sync);
    for (int k = 0; k < 4; k++)
      step(tag, 1'b1, (k == 0) ? first_sync : 1'b0, bits[k]);
  endtask

  initial begin
    CE = 1'b0; SYNC = 1'b0; D = 1'b0;
    CLR = 1'b1;
    model_reset();
    #3;
    chk("reset_q_lsb", {l_q3, l_q2, l_q1, l_q0}, C_INIT);
    chk("reset_valid", {2'b0, l_valid, m_valid}, 4'b0);
    #4 CLR = 1'b0;

    // Word 1,0,1,1 then 0,1,1,0 back to back (bits listed as bit0..bit3).
    send_word("w1", 4'b1101, 1'b1);
    chk("w1_q_const", {l_q3, l_q2, l_q1, l_q0}, 4'b1101);
    send_word("w2", 4'b0110, 1'b0);
    chk("w2_q_const", {l_q3, l_q2, l_q1, l_q0}, 4'b0110);
    step("w2_after", 1'b0, 1'b0, 1'b0);

    // Early SYNC after two bits, then a full 1111 word led by that SYNC.
    step("es_b0", 1'b1, 1'b0, 1'b1);
    step("es_b1", 1'b1, 1'b0, 1'b0);
    step("es_sync", 1'b1, 1'b1, 1'b1);
    chk("es_err_const", {2'b0, l_err, m_err}, 4'b0011);
    step("es_b1b", 1'b1, 1'b0, 1'b1);
    step("es_b2b", 1'b1, 1'b0, 1'b1);
    step("es_b3b", 1'b1, 1'b0, 1'b1);
    chk("es_q_const", {l_q3, l_q2, l_q1, l_q0}, 4'b1111);

    // CE gating between bits; VALID must drop on the following CE=0 edge.
    step("ce_b0", 1'b1, 1'b1, 1'b0);
    step("ce_g0", 1'b0, 1'b0, 1'b1);
    step("ce_b1", 1'b1, 1'b0, 1'b1);
    step("ce_g1", 1'b0, 1'b1, 1'b0);
    step("ce_b2", 1'b1, 1'b0, 1'b0);
    step("ce_g2", 1'b0, 1'b0, 1'b1);
    step("ce_b3", 1'b1, 1'b0, 1'b1);
    chk("ce_valid_const", {2'b0, l_valid, m_valid}, 4'b0011);
    step("ce_g3", 1'b0, 1'b0, 1'b0);
    chk("ce_pulse_const", {2'b0, l_valid, m_valid}, 4'b0000);

    // Hunt: data without SYNC after a reset must never produce a word.
    async_clear("hunt_clr");
    for (int i = 0; i < 6; i++) step("hunt", 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // MSB-first bit order: bits 1,0,0,0 land on Q3.
    send_word("msb", 4'b0001, 1'b1);
    chk("msb_q_const", {m_q3, m_q2, m_q1, m_q0}, 4'b1000);

    // Mid-word reset discards the partial word; next word decodes cleanly.
    step("mw_b0", 1'b1, 1'b1, 1'b1);
    step("mw_b1", 1'b1, 1'b0, 1'b1);
    async_clear("mw_clr");
    step("mw_noword", 1'b1, 1'b0, 1'b1);
    send_word("mw_next", 4'b1001, 1'b1);
    chk("mw_q_const", {l_q3, l_q2, l_q1, l_q0}, 4'b1001);

    // Randomized traffic: mostly-enabled, sparse SYNC, occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_clear("rnd_clr");
      else step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
